// File: rtl/aes_key_schedule_seq.sv
// Sequential AES key expansion: loads a 128/192/256-bit key, produces one schedule
// word per clock into a register array, then serves round keys by index.
module aes_key_schedule_seq #(
    parameter int KEY_W     = 256,
    parameter int MAX_WORDS = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       key_len,
    input  logic [KEY_W-1:0] key_in,
    input  logic [3:0]       rk_idx,
    output logic [127:0]     rk_out,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    output logic             key_err
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, EXPAND} state_t;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        sub_byte = SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        sub_word = {sub_byte(x[31:24]), sub_byte(x[23:16]), sub_byte(x[15:8]), sub_byte(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    state_t      state, state_next;
    logic [31:0] w [MAX_WORDS];
    logic [3:0]  nk, nr, nk_new;
    logic [5:0]  idx, last_idx, rk_base;
    logic [2:0]  j;
    logic [7:0]  rcon;
    logic [31:0] prev, temp;
    logic        len_ok, accept, last_word;

    // Key length 16/24/32 bytes maps directly to Nk = 4/6/8 via bits [5:2].
    assign nk_new    = key_len[5:2];
    assign len_ok    = (key_len == 8'd16) || (key_len == 8'd24) || (key_len == 8'd32);
    assign accept    = (state == IDLE) && start && len_ok;
    assign last_word = (state == EXPAND) && (idx == last_idx);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)            state_next = EXPAND;
            EXPAND:  if (idx == last_idx)   state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == EXPAND);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done       <= 1'b0;
            key_err    <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            done    <= 1'b0;
            key_err <= 1'b0;
            if (state == IDLE && start) begin
                keys_valid <= 1'b0;
                key_err    <= !len_ok;
            end
            if (last_word) begin
                done       <= 1'b1;
                keys_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        prev = w[idx - 6'd1];
        temp = prev;
        if (j == 3'd0)
            temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
        else if (nk == 4'd8 && j == 3'd4)
            temp = sub_word(prev);
    end

    // Word array and schedule counters carry no reset; they are reloaded on every accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            nk       <= nk_new;
            nr       <= nk_new + 4'd6;
            last_idx <= {nk_new, 2'b00} + 6'd27;
            idx      <= {2'b00, nk_new};
            j        <= 3'd0;
            rcon     <= 8'h01;
            for (int k = 0; k < 8; k++) begin
                if (k < int'(nk_new)) w[k] <= key_in[KEY_W-1-32*k -: 32];
            end
        end else if (state == EXPAND) begin
            w[idx] <= w[idx - {2'b00, nk}] ^ temp;
            idx    <= idx + 6'd1;
            j      <= ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
            if (j == 3'd0) rcon <= xtime(rcon);
        end
    end

    always_comb begin
        rk_base = {rk_idx, 2'b00};
        rk_out  = 128'h0;
        if (keys_valid && rk_idx <= nr)
            rk_out = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
    end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq using the FIPS-197 appendix A key vectors.
module tb_aes_key_schedule_seq;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   key_len = 8'd16;
    logic [255:0] key_in = '0;
    logic [3:0]   rk_idx = 4'd0;
    logic [127:0] rk_out;
    logic         busy, done, keys_valid, key_err;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    aes_key_schedule_seq #(.KEY_W(256), .MAX_WORDS(60)) dut (
        .clk(clk), .reset(reset), .start(start), .key_len(key_len), .key_in(key_in),
        .rk_idx(rk_idx), .rk_out(rk_out), .busy(busy), .done(done),
        .keys_valid(keys_valid), .key_err(key_err)
    );

    task automatic run_expand(input logic [7:0] len, input logic [255:0] key, input int repulse_at,
                              output int lat, output int busy_cycles, output int kv_cycles);
        int err_cycles;
        start = 1'b1; key_len = len; key_in = key;
        @(posedge clk); #1;
        start = 1'b0;
        key_in = ~key;
        key_len = (len == 8'd24) ? 8'd16 : 8'd24;
        lat = 0; busy_cycles = 0; kv_cycles = 0; err_cycles = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            if (keys_valid) kv_cycles++;
            if (key_err) err_cycles++;
            if (lat == 5) begin
                rk_idx = 4'd0; #1;
                vectors++;
                if (rk_out !== 128'h0) begin
                    miscompares++;
                    $display("FAIL rk_out_during_expand: got %h want 0", rk_out);
                end
            end
            start = (lat == repulse_at);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        vectors++;
        if (err_cycles !== 0) begin
            miscompares++;
            $display("FAIL key_err_during_expand: got %0d cycles want 0", err_cycles);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, keys_valid, key_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, keys_valid, key_err});
        end
        vectors++;
        if (rk_out !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_rk_out: got %h want 0", rk_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_aes128();
        int lat, bc, kv;
        run_expand(8'd16, K128, -1, lat, bc, kv);
        vectors++;
        if (lat !== 40) begin miscompares++; $display("FAIL aes128_latency: got %0d want 40", lat); end
        vectors++;
        if (bc !== 40) begin miscompares++; $display("FAIL aes128_busy_cycles: got %0d want 40", bc); end
        vectors++;
        if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL aes128_keys_valid: got %b want 1", keys_valid); end
        rk_idx = 4'd10; #1;
        vectors++;
        if (rk_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            miscompares++; $display("FAIL aes128_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk_out);
        end
        rk_idx = 4'd0; #1;
        vectors++;
        if (rk_out !== K128[255:128]) begin
            miscompares++; $display("FAIL aes128_rk0: got %h want %h", rk_out, K128[255:128]);
        end
        rk_idx = 4'd1; #1;
        vectors++;
        if (rk_out !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            miscompares++; $display("FAIL aes128_rk1: got %h want a0fafe1788542cb123a339392a6c7605", rk_out);
        end
        rk_idx = 4'd11; #1;
        vectors++;
        if (rk_out !== 128'h0) begin miscompares++; $display("FAIL aes128_rk11: got %h want 0", rk_out); end
        @(posedge clk); #1;
        vectors++;
        if ({done, keys_valid} !== 2'b01) begin
            miscompares++; $display("FAIL aes128_done_pulse: got done,kv=%b want 01", {done, keys_valid});
        end
    endtask

    task automatic test_aes192();
        int lat, bc, kv;
        run_expand(8'd24, K192, -1, lat, bc, kv);
        vectors++;
        if (lat !== 46) begin miscompares++; $display("FAIL aes192_latency: got %0d want 46", lat); end
        vectors++;
        if (bc !== 46) begin miscompares++; $display("FAIL aes192_busy_cycles: got %0d want 46", bc); end
        rk_idx = 4'd12; #1;
        vectors++;
        if (rk_out !== 128'he98ba06f448c773c8ecc720401002202) begin
            miscompares++; $display("FAIL aes192_rk12: got %h want e98ba06f448c773c8ecc720401002202", rk_out);
        end
        rk_idx = 4'd13; #1;
        vectors++;
        if (rk_out !== 128'h0) begin miscompares++; $display("FAIL aes192_rk13: got %h want 0", rk_out); end
        rk_idx = 4'd0; #1;
        vectors++;
        if (rk_out !== K192[255:128]) begin
            miscompares++; $display("FAIL aes192_rk0: got %h want %h", rk_out, K192[255:128]);
        end
        rk_idx = 4'd1; #1;
        vectors++;
        if (rk_out !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5) begin
            miscompares++; $display("FAIL aes192_rk1: got %h want 62f8ead2522c6b7bfe0c91f72402f5a5", rk_out);
        end
    endtask

    task automatic test_aes256();
        int lat, bc, kv;
        run_expand(8'd32, K256, -1, lat, bc, kv);
        vectors++;
        if (lat !== 52) begin miscompares++; $display("FAIL aes256_latency: got %0d want 52", lat); end
        vectors++;
        if (bc !== 52) begin miscompares++; $display("FAIL aes256_busy_cycles: got %0d want 52", bc); end
        rk_idx = 4'd14; #1;
        vectors++;
        if (rk_out !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            miscompares++; $display("FAIL aes256_rk14: got %h want fe4890d1e6188d0b046df344706c631e", rk_out);
        end
        rk_idx = 4'd1; #1;
        vectors++;
        if (rk_out !== K256[127:0]) begin
            miscompares++; $display("FAIL aes256_rk1: got %h want %h", rk_out, K256[127:0]);
        end
        rk_idx = 4'd2; #1;
        vectors++;
        if (rk_out !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin
            miscompares++; $display("FAIL aes256_rk2: got %h want 9ba354118e6925afa51a8b5f2067fcde", rk_out);
        end
        rk_idx = 4'd15; #1;
        vectors++;
        if (rk_out !== 128'h0) begin miscompares++; $display("FAIL aes256_rk15: got %h want 0", rk_out); end
    endtask

    task automatic test_bad_len();
        start = 1'b1; key_len = 8'd20; key_in = K128; rk_idx = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if ({key_err, busy, keys_valid} !== 3'b100) begin
            miscompares++; $display("FAIL badlen_flags: got err,busy,kv=%b want 100", {key_err, busy, keys_valid});
        end
        vectors++;
        if (rk_out !== 128'h0) begin miscompares++; $display("FAIL badlen_rk_out: got %h want 0", rk_out); end
        @(posedge clk); #1;
        vectors++;
        if ({key_err, busy} !== 2'b00) begin
            miscompares++; $display("FAIL badlen_pulse: got err,busy=%b want 00", {key_err, busy});
        end
    endtask

    task automatic test_restart_ignored();
        int lat, bc, kv;
        run_expand(8'd16, K128, 10, lat, bc, kv);
        vectors++;
        if (lat !== 40) begin miscompares++; $display("FAIL repulse_latency: got %0d want 40", lat); end
        rk_idx = 4'd10; #1;
        vectors++;
        if (rk_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            miscompares++; $display("FAIL repulse_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk_out);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, kv, done_seen;
        start = 1'b1; key_len = 8'd16; key_in = K128;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++;
        if ({busy, keys_valid, done} !== 3'b000) begin
            miscompares++; $display("FAIL midreset_flags: got busy,kv,done=%b want 000", {busy, keys_valid, done});
        end
        done_seen = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        vectors++;
        if (done_seen !== 0) begin miscompares++; $display("FAIL midreset_no_done: got %0d want 0", done_seen); end
        run_expand(8'd16, K128, -1, lat, bc, kv);
        vectors++;
        if (lat !== 40) begin miscompares++; $display("FAIL midreset_rerun_latency: got %0d want 40", lat); end
        rk_idx = 4'd10; #1;
        vectors++;
        if (rk_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            miscompares++; $display("FAIL midreset_rerun_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk_out);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, kv;
        run_expand(8'd16, K128, -1, lat, bc, kv);
        run_expand(8'd32, K256, -1, lat, bc, kv);
        vectors++;
        if (lat !== 52) begin miscompares++; $display("FAIL b2b_latency: got %0d want 52", lat); end
        vectors++;
        if (kv !== 0) begin miscompares++; $display("FAIL b2b_keys_valid_during_run: got %0d want 0", kv); end
        rk_idx = 4'd14; #1;
        vectors++;
        if (rk_out !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            miscompares++; $display("FAIL b2b_rk14: got %h want fe4890d1e6188d0b046df344706c631e", rk_out);
        end
        rk_idx = 4'd2; #1;
        vectors++;
        if (rk_out !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin
            miscompares++; $display("FAIL b2b_rk2: got %h want 9ba354118e6925afa51a8b5f2067fcde", rk_out);
        end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_bad_len();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
